// File: rtl/control_pkg.sv
// control_pkg: shared definitions for the multicycle sequencer.
//   - opcode constants decoded from the IR opcode field
//   - state encodings, which are also visible on the STATE debug port
//   - PC source (FONTECP) and ULA operation encodings
//   - classification helpers for memory-wait and retiring states
package control_pkg;

  localparam logic [3:0] OP_JUMP  = 4'b1011;
  localparam logic [3:0] OP_BEQ   = 4'b1100;
  localparam logic [3:0] OP_LOAD  = 4'b1101;
  localparam logic [3:0] OP_STORE = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [3:0] ULA_ADD = 4'b0000;
  localparam logic [3:0] ULA_SUB = 4'b0001;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_WB_ALU = 4'd4,
    S_JUMP   = 4'd5,
    S_BRANCH = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_MEM_WR = 4'd9,
    S_WB_MEM = 4'd10,
    S_HALT   = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    PC_ULA    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  // States that hold a memory request open and wait on MEM_READY.
  function automatic logic is_mem_wait(input state_e s);
    return s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  endfunction

  // States whose exit to FETCH completes (retires) an instruction.
  function automatic logic retires(input state_e s);
    return s inside {S_WB_ALU, S_WB_MEM, S_MEM_WR, S_JUMP, S_BRANCH};
  endfunction

endpackage

// File: rtl/mem_timer.sv
// mem_timer: counts consecutive cycles a memory access has waited.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear_i     : restart the count (not waiting, or access completing)
//   waiting_i   : in a memory state with MEM_READY low this cycle
//   expired_o   : this waiting cycle is the last one allowed
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module mem_timer
  import control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic waiting_i,
  output logic expired_o
);

  localparam bit            ENABLED = (TIMEOUT_CYCLES > 0);
  localparam logic [TO_W-1:0] LIMIT = TO_W'(ENABLED ? TIMEOUT_CYCLES - 1 : 0);

  logic [TO_W-1:0] count_q;

  // NOTE: sequential state is updated with non-blocking assignments only,
  // so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (waiting_i) begin
      count_q <= count_q + TO_W'(1);
    end
  end

  // Count k means k earlier waiting cycles, so the fault fires on wait cycle
  // number TIMEOUT_CYCLES; a ready on that same cycle still wins upstream.
  assign expired_o = ENABLED && waiting_i && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle instruction sequencer.
// Steps each instruction through FETCH/DECODE/EXEC/memory/writeback states,
// driving datapath enables and muxes and a req/ready memory handshake that
// is guarded by a timeout (sticky ERRO, core halts).
// Ports:
//   CLK, RST_N          clock, asynchronous active-low reset
//   CODOP[3:0]          opcode from IR, sampled in DECODE
//   MEM_READY           memory completes the current access this cycle
//   MEM_REQ, MEM_WE     memory request and direction (1 = write)
//   IOUD                memory address source: 0 = PC, 1 = ULA result
//   ESCIR, ESCCP        IR write, unconditional PC write
//   ESCCONDCP           PC write when the ULA result is zero
//   FONTECP[1:0]        PC source (PC_ULA / PC_BRANCH / PC_JUMP)
//   ULA_OP[3:0]         ULA operation
//   ESCREG, MEMPARAREG  register write enable, write-data source (1 = memory)
//   HALTED, ERRO        core stopped, sticky memory-timeout fault
//   STATE[3:0]          current state encoding (debug)
//   INSTR_COUNT[31:0]   retired instructions
// Optional feature macro: INSTR_COUNT_EN (undefined: INSTR_COUNT tied to 0).
module multicycle_control
  import control_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  CODOP,
  input  logic        MEM_READY,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic        IOUD,
  output logic        ESCIR,
  output logic        ESCCP,
  output logic        ESCCONDCP,
  output logic [1:0]  FONTECP,
  output logic [3:0]  ULA_OP,
  output logic        ESCREG,
  output logic        MEMPARAREG,
  output logic        HALTED,
  output logic        ERRO,
  output logic [3:0]  STATE,
  output logic [31:0] INSTR_COUNT
);

  state_e     state_q, state_d;
  logic [3:0] opcode_q;
  logic       erro_q;
  logic       in_wait, mem_waiting, timer_clear, expired;

  // MEM_READY only matters inside the three memory-wait states.
  assign in_wait     = is_mem_wait(state_q);
  assign mem_waiting = in_wait && !MEM_READY;
  assign timer_clear = !in_wait || MEM_READY;

  mem_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_mem_timer (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clear_i  (timer_clear),
    .waiting_i(mem_waiting),
    .expired_o(expired)
  );

  // NOTE: state_d gets a default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  if (MEM_READY) state_d = S_DECODE;
                else if (expired) state_d = S_HALT;
      S_DECODE: begin
        case (CODOP)
          OP_JUMP:            state_d = S_JUMP;
          OP_BEQ:             state_d = S_BRANCH;
          OP_LOAD, OP_STORE:  state_d = S_ADDR;
          OP_HALT:            state_d = S_HALT;
          default:            state_d = S_EXEC;
        endcase
      end
      S_EXEC:   state_d = S_WB_ALU;
      S_WB_ALU, S_JUMP, S_BRANCH, S_WB_MEM: state_d = S_FETCH;
      // Only loads and stores reach ADDR, so one compare picks the path.
      S_ADDR:   state_d = (opcode_q == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: if (MEM_READY) state_d = S_WB_MEM;
                else if (expired) state_d = S_HALT;
      S_MEM_WR: if (MEM_READY) state_d = S_FETCH;
                else if (expired) state_d = S_HALT;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // NOTE: every control flop, including the opcode latch, is reset so that
  // nothing depends on power-up contents.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_INIT;
      opcode_q <= '0;
      erro_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) opcode_q <= CODOP;
      if (expired)             erro_q   <= 1'b1;
    end
  end

  always_comb begin
    MEM_REQ    = 1'b0;
    MEM_WE     = 1'b0;
    IOUD       = 1'b0;
    ESCIR      = 1'b0;
    ESCCP      = 1'b0;
    ESCCONDCP  = 1'b0;
    FONTECP    = PC_ULA;
    ULA_OP     = ULA_ADD;
    ESCREG     = 1'b0;
    MEMPARAREG = 1'b0;
    HALTED     = 1'b0;
    case (state_q)
      S_FETCH: begin
        MEM_REQ = 1'b1;
        // IR and PC+1 are written only in the cycle the fetch completes.
        if (MEM_READY) begin
          ESCIR = 1'b1;
          ESCCP = 1'b1;
        end
      end
      S_EXEC:   ULA_OP = opcode_q;
      S_WB_ALU: begin
        ULA_OP = opcode_q;
        ESCREG = 1'b1;
      end
      S_JUMP: begin
        ESCCP   = 1'b1;
        FONTECP = PC_JUMP;
      end
      S_BRANCH: begin
        ESCCONDCP = 1'b1;
        FONTECP   = PC_BRANCH;
        ULA_OP    = ULA_SUB;
      end
      S_MEM_RD: begin
        MEM_REQ = 1'b1;
        IOUD    = 1'b1;
      end
      S_MEM_WR: begin
        MEM_REQ = 1'b1;
        MEM_WE  = 1'b1;
        IOUD    = 1'b1;
      end
      S_WB_MEM: begin
        ESCREG     = 1'b1;
        MEMPARAREG = 1'b1;
      end
      S_HALT:   HALTED = 1'b1;
      default:  ;
    endcase
  end

  assign ERRO  = erro_q;
  assign STATE = state_q;

`ifdef INSTR_COUNT_EN
  logic [31:0] count_q;

  // HALT never returns to FETCH, so the count freezes there by construction.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
    end else if (state_d == S_FETCH && retires(state_q)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign INSTR_COUNT = count_q;
`else
  assign INSTR_COUNT = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a directed table of
// instructions, hand-written corner sequences (timeouts, halt, resets) and
// randomized instructions, all checked cycle by cycle against an expected
// trace generated from the instruction class and the chosen wait counts.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  CODOP;
  logic        MEM_READY;
  logic        MEM_REQ, MEM_WE, IOUD, ESCIR, ESCCP, ESCCONDCP;
  logic [1:0]  FONTECP;
  logic [3:0]  ULA_OP;
  logic        ESCREG, MEMPARAREG, HALTED, ERRO;
  logic [3:0]  STATE;
  logic [31:0] INSTR_COUNT;

  multicycle_control #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .CODOP(CODOP), .MEM_READY(MEM_READY),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .IOUD(IOUD), .ESCIR(ESCIR),
    .ESCCP(ESCCP), .ESCCONDCP(ESCCONDCP), .FONTECP(FONTECP), .ULA_OP(ULA_OP),
    .ESCREG(ESCREG), .MEMPARAREG(MEMPARAREG), .HALTED(HALTED), .ERRO(ERRO),
    .STATE(STATE), .INSTR_COUNT(INSTR_COUNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit       exp_erro;
  int unsigned exp_count;

  localparam logic [14:0] IDLE = 15'd0;

  typedef struct {
    logic [3:0] op;
    int         fw;   // FETCH wait cycles before MEM_READY
    int         mw;   // MEM_RD/MEM_WR wait cycles before MEM_READY
    string      name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Packs the expected control outputs in the same order as act_outs().
  function automatic logic [14:0] ov(input bit req, input bit we, input bit ioud,
                                     input bit escir, input bit esccp, input bit escc,
                                     input bit [1:0] fcp, input bit [3:0] ula,
                                     input bit escreg, input bit mpr, input bit halted);
    return {req, we, ioud, escir, esccp, escc, fcp, ula, escreg, mpr, halted};
  endfunction

  function automatic logic [14:0] act_outs();
    return {MEM_REQ, MEM_WE, IOUD, ESCIR, ESCCP, ESCCONDCP, FONTECP, ULA_OP,
            ESCREG, MEMPARAREG, HALTED};
  endfunction

  task automatic compare(input string tag, input logic [3:0] st, input logic [14:0] o);
    check({tag, " ctrl"}, {STATE, act_outs(), ERRO}, {st, o, exp_erro});
`ifdef INSTR_COUNT_EN
    check({tag, " count"}, INSTR_COUNT, exp_count);
`else
    check({tag, " count"}, INSTR_COUNT, 32'd0);
`endif
  endtask

  // One clock cycle: entered just after a rising edge, inputs driven, outputs
  // sampled on the falling edge, returns just after the next rising edge.
  task automatic cyc(input bit rdy, input logic [3:0] st, input logic [14:0] o, input string tag);
    MEM_READY = rdy;
    @(negedge CLK);
    compare($sformatf("%s s%0d", tag, st), st, o);
    @(posedge CLK);
    #1;
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic do_reset(input string tag);
    RST_N = 1'b0;
    #1;
    exp_erro  = 1'b0;
    exp_count = 0;
    compare({tag, " async"}, 4'd0, IDLE);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    cyc(rb(), 4'd0, IDLE, {tag, " init"});
  endtask

  task automatic do_fetch(input logic [3:0] op, input int fw, input string tag);
    for (int i = 0; i < fw; i++) begin
      CODOP = 4'($urandom);
      cyc(1'b0, 4'd1, ov(1,0,0,0,0,0,2'b00,4'd0,0,0,0), tag);
    end
    CODOP = 4'($urandom);
    cyc(1'b1, 4'd1, ov(1,0,0,1,1,0,2'b00,4'd0,0,0,0), tag);
    CODOP = op;
    cyc(rb(), 4'd2, IDLE, tag);
    CODOP = 4'($urandom);   // opcode must now come from the latch
  endtask

  // Runs one instruction to completion (or to its first HALT cycle).
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input string tag);
    bit st_w;
    do_fetch(op, fw, tag);
    if (op == 4'b1011) begin
      cyc(rb(), 4'd5, ov(0,0,0,0,1,0,2'b10,4'd0,0,0,0), tag);
    end else if (op == 4'b1100) begin
      cyc(rb(), 4'd6, ov(0,0,0,0,0,1,2'b01,4'd1,0,0,0), tag);
    end else if (op == 4'b1101 || op == 4'b1110) begin
      st_w = (op == 4'b1110);
      cyc(rb(), 4'd7, IDLE, tag);
      for (int i = 0; i <= mw; i++)
        cyc(i == mw, st_w ? 4'd9 : 4'd8, ov(1,st_w,1,0,0,0,2'b00,4'd0,0,0,0), tag);
      if (!st_w) cyc(rb(), 4'd10, ov(0,0,0,0,0,0,2'b00,4'd0,1,1,0), tag);
    end else if (op == 4'b1111) begin
      cyc(rb(), 4'd11, ov(0,0,0,0,0,0,2'b00,4'd0,0,0,1), tag);
    end else begin
      cyc(rb(), 4'd3, ov(0,0,0,0,0,0,2'b00,op,0,0,0), tag);
      cyc(rb(), 4'd4, ov(0,0,0,0,0,0,2'b00,op,1,0,0), tag);
    end
    if (op != 4'b1111) exp_count++;
  endtask

  task automatic halt_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++)
      cyc(rb(), 4'd11, ov(0,0,0,0,0,0,2'b00,4'd0,0,0,1), tag);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{4'b0011, 0, 0,  "alu0011"};
    vecs[1] = '{4'b1101, 0, 3,  "load_w3"};
    vecs[2] = '{4'b1011, 0, 0,  "jump"};
    vecs[3] = '{4'b1100, 0, 0,  "branch"};
    vecs[4] = '{4'b1110, 2, 1,  "store_w"};
    vecs[5] = '{4'b0000, 1, 0,  "alu0000"};
    vecs[6] = '{4'b1010, 0, 0,  "alu1010"};
    vecs[7] = '{4'b0101, 15, 0, "fetch_limit_ok"};
    vecs[8] = '{4'b1101, 0, 15, "load_limit_ok"};
    vecs[9] = '{4'b1110, 0, 15, "store_limit_ok"};

    RST_N = 1'b0; MEM_READY = 1'b0; CODOP = 4'd0;
    exp_erro = 1'b0; exp_count = 0;
    repeat (2) @(posedge CLK);
    #1;
    do_reset("rst0");

    foreach (vecs[i]) run_instr(vecs[i].op, vecs[i].fw, vecs[i].mw, vecs[i].name);

    // Random instruction mix, short waits with occasional boundary waits.
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      int fw, mw;
      op = 4'($urandom_range(0, 14));
      fw = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      run_instr(op, fw, mw, $sformatf("rand%0d", n));
    end

    // Reset in the middle of a waiting fetch drops MEM_REQ at once.
    CODOP = 4'd0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'd1, ov(1,0,0,0,0,0,2'b00,4'd0,0,0,0), "midfetch");
    do_reset("rst_mid");

    // Fetch timeout: 16 FETCH cycles without ready, then sticky fault.
    for (int i = 0; i < 16; i++) cyc(1'b0, 4'd1, ov(1,0,0,0,0,0,2'b00,4'd0,0,0,0), "to_fetch");
    exp_erro = 1'b1;
    halt_cycles(5, "to_halt");
    do_reset("rst_to");

    // Store timeout in MEM_WR: instruction does not retire.
    run_instr(4'b0001, 0, 0, "pre_store");
    do_fetch(4'b1110, 0, "to_store");
    cyc(rb(), 4'd7, IDLE, "to_store");
    for (int i = 0; i < 16; i++) cyc(1'b0, 4'd9, ov(1,1,1,0,0,0,2'b00,4'd0,0,0,0), "to_store");
    exp_erro = 1'b1;
    halt_cycles(4, "to_store_halt");
    do_reset("rst_to2");

    // Retire count: 3 ALU + store + halt, count freezes in HALT.
    run_instr(4'b0010, 0, 0, "cnt_alu1");
    run_instr(4'b0111, 1, 0, "cnt_alu2");
    run_instr(4'b1001, 0, 0, "cnt_alu3");
    run_instr(4'b1110, 0, 2, "cnt_store");
    run_instr(4'b1111, 0, 0, "cnt_halt");
    for (int i = 0; i < 6; i++) begin
      MEM_READY = 1'b1;
      @(negedge CLK);
      compare("halt_pulse", 4'd11, ov(0,0,0,0,0,0,2'b00,4'd0,0,0,1));
      @(posedge CLK);
      #1;
    end

    // Reset in HALT returns to INIT with all outputs low.
    do_reset("rst_halt");
    run_instr(4'b0100, 0, 0, "post_halt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle sequencer for the processor datapath (IR, PC, register file, ULA, unified memory). It steps each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath write-enables and muxes, and runs a req/ready handshake with memory guarded by a timeout. It replaces ad-hoc flag sequencing with an explicit state machine and adds load/store plus halt.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waiting on MEM_READY before fault; 0 disables timeout
TO_W, 5, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
CLK  in  1  clock; all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
CODOP  in  4  opcode field from IR; valid from DECODE onward
MEM_READY  in  1  memory completes current access this cycle
MEM_REQ  out  1  memory access request
MEM_WE  out  1  1=write, 0=read; valid with MEM_REQ
IOUD  out  1  memory address source: 0=PC, 1=ULA result
ESCIR  out  1  IR write enable
ESCCP  out  1  unconditional PC write
ESCCONDCP  out  1  PC write if ULA zero
FONTECP  out  2  PC source: 00=ULA (PC+1), 01=branch target, 10=jump target
ULA_OP  out  4  ULA operation
ESCREG  out  1  register file write enable
MEMPARAREG  out  1  register write data: 0=ULA, 1=memory
HALTED  out  1  core stopped
ERRO  out  1  sticky memory-timeout fault
STATE  out  4  current state encoding (debug)
INSTR_COUNT  out  32  retired instructions (see Optional Feature)

Behaviour:
- Reset (RST_N low, async): state=INIT, opcode latch=0, timeout count=0, ERRO=0. All outputs 0 while in INIT; STATE=0.
- Outputs decode combinationally from registered state, the opcode latch and MEM_READY. Any output not listed for a state is 0.
- State encodings: INIT=0, FETCH=1, DECODE=2, EXEC=3, WB_ALU=4, JUMP=5, BRANCH=6, ADDR=7, MEM_RD=8, MEM_WR=9, WB_MEM=10, HALT=11.
- INIT: moves to FETCH after one cycle.
- FETCH: MEM_REQ=1, IOUD=0, ULA_OP=0000.
  - In the cycle MEM_READY=1: ESCIR=1, ESCCP=1, FONTECP=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: latch CODOP. Next state by CODOP:
  - 1011 -> JUMP
  - 1100 -> BRANCH
  - 1101 (load) or 1110 (store) -> ADDR
  - 1111 -> HALT
  - 0000-1010 -> EXEC
- EXEC: ULA_OP=latch, then WB_ALU.
- WB_ALU: ULA_OP=latch, ESCREG=1, MEMPARAREG=0, then FETCH.
- JUMP: ESCCP=1, FONTECP=10, then FETCH.
- BRANCH: ESCCONDCP=1, FONTECP=01, ULA_OP=0001 (subtract/compare), then FETCH.
- ADDR: ULA_OP=0000. Latch 1101 -> MEM_RD; latch 1110 -> MEM_WR.
- MEM_RD: MEM_REQ=1, IOUD=1, MEM_WE=0. On MEM_READY -> WB_MEM.
- WB_MEM: ESCREG=1, MEMPARAREG=1, then FETCH.
- MEM_WR: MEM_REQ=1, MEM_WE=1, IOUD=1. On MEM_READY -> FETCH.
- HALT: HALTED=1. Terminal; only reset exits.
- Latency with zero-wait memory (MEM_READY high in the first FETCH/MEM cycle):
  - ALU: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - jump/branch: 3 cycles
- Each memory wait state adds one cycle.
- Timeout:
  - The counter clears on entry to FETCH, MEM_RD or MEM_WR.
  - It increments each cycle spent in one of those states with MEM_READY=0.
  - When count reaches TIMEOUT_CYCLES-1 with MEM_READY still 0: next state HALT, ERRO set (sticky until reset). MEM_REQ drops on the HALT cycle.
  - If MEM_READY=1 on the limit cycle, the access completes normally; no fault.
- MEM_READY is ignored outside FETCH, MEM_RD and MEM_WR.
- Reset asserted mid-access drops MEM_REQ immediately (asynchronous).

Optional Feature:
INSTR_COUNT_EN
- Defined: INSTR_COUNT increments on every transition into FETCH from WB_ALU, WB_MEM, MEM_WR, JUMP or BRANCH. It wraps at 2^32, resets to 0, and freezes in HALT.
- Undefined: INSTR_COUNT is tied to 0 and no counter flops exist.

Decomposition:
- control_pkg holds:
  - opcode constants: OP_JUMP=1011, OP_BEQ=1100, OP_LOAD=1101, OP_STORE=1110, OP_HALT=1111
  - the state enum/encodings
  - FONTECP encodings: PC_ULA, PC_BRANCH, PC_JUMP
  - ULA_ADD=0000, ULA_SUB=0001
- One sub-module, mem_timer: the timeout counter. Inputs: clear, waiting. Output: expired.

Test Plan:
- Reset, then ALU op 0011 with MEM_READY tied 1 -> STATE sequence 0,1,2,3,4,1; ESCIR=ESCCP=1 in FETCH; ESCREG=1 with ULA_OP=0011 in WB_ALU.
- Load 1101 with MEM_READY delayed 3 cycles in MEM_RD -> IOUD=1 for 4 cycles, then WB_MEM with MEMPARAREG=1, ESCREG=1; total 8 cycles.
- Jump 1011 -> JUMP with ESCCP=1, FONTECP=10; branch 1100 -> ESCCONDCP=1, FONTECP=01, ULA_OP=0001, ESCCP=0.
- MEM_READY held 0 in FETCH with TIMEOUT_CYCLES=16 -> HALT after 16 FETCH cycles; ERRO=1 and HALTED=1 persist; MEM_REQ=0.
- Opcode 1111 -> HALT after DECODE; later MEM_READY pulses cause no change; RST_N low mid-HALT -> INIT, all outputs 0.
- With INSTR_COUNT_EN: 3 ALU ops + 1 store + halt -> INSTR_COUNT=4 and stays 4.
